// File: rtl/sad_score.sv
// sad_score: scoring back end of the template-matching datapath.
// Popcounts one DATA_W-bit mismatch vector per window, CHUNK_W bits per cycle,
// and tracks the lowest score of each frame together with its window index.

module sad_score #(
   parameter int DATA_W  = 4000,
   parameter int CHUNK_W = 200,
   parameter int CNT_W   = 12,
   parameter int POS_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] d_in,
   input  logic              d_valid,
   input  logic              d_last,
   output logic              d_ready,
   output logic [CNT_W-1:0]  score,
   output logic              score_valid,
   output logic [CNT_W-1:0]  best_score,
   output logic [POS_W-1:0]  best_pos,
   output logic              best_valid
);

   localparam int NCHUNK = DATA_W / CHUNK_W;
   localparam int PC_W   = $clog2(CHUNK_W + 1);
   localparam int CC_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CC_W-1:0] LAST_CHUNK = CC_W'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0]  acc;
   logic [CC_W-1:0]   chunk_cnt;
   logic              last_win;
   logic [POS_W-1:0]  win_idx;
   logic              first_win;
   logic [CNT_W-1:0]  run_min;
   logic [POS_W-1:0]  run_pos;

   logic [PC_W-1:0]   chunk_pop;
   logic [CNT_W-1:0]  sum;
   logic              take;
   logic [CNT_W-1:0]  new_min;
   logic [POS_W-1:0]  new_pos;
   logic              transfer;
   logic              final_chunk;

   assign d_ready     = (state == IDLE);
   assign transfer    = d_valid && d_ready;
   assign final_chunk = (state == COUNT) && (chunk_cnt == LAST_CHUNK);

   // Popcount of the low chunk of the shift register (LSB chunk goes first).
   always_comb begin
      chunk_pop = '0;
      for (int i = 0; i < CHUNK_W; i++) begin
         chunk_pop = chunk_pop + PC_W'(shreg[i]);
      end
   end

   // Running sum and best-match candidate; strict less-than keeps the earliest window on ties.
   always_comb begin
      sum     = acc + CNT_W'(chunk_pop);
      take    = first_win || (sum < run_min);
      new_min = take ? sum : run_min;
      new_pos = take ? win_idx : run_pos;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode: accept a window, count its chunks, then one DONE cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (transfer) state_nxt = COUNT;
         COUNT:   if (final_chunk) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: load, shift-and-accumulate, score/best registration and frame bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg       <= '0;
         acc         <= '0;
         chunk_cnt   <= '0;
         last_win    <= 1'b0;
         win_idx     <= '0;
         first_win   <= 1'b1;
         run_min     <= '0;
         run_pos     <= '0;
         score       <= '0;
         score_valid <= 1'b0;
         best_score  <= '0;
         best_pos    <= '0;
         best_valid  <= 1'b0;
      end else begin
         score_valid <= 1'b0;
         best_valid  <= 1'b0;
         case (state)
            IDLE: begin
               if (transfer) begin
                  shreg     <= d_in;
                  last_win  <= d_last;
                  acc       <= '0;
                  chunk_cnt <= '0;
               end
            end
            COUNT: begin
               acc       <= sum;
               shreg     <= shreg >> CHUNK_W;
               chunk_cnt <= chunk_cnt + CC_W'(1);
               if (final_chunk) begin
                  score       <= sum;
                  score_valid <= 1'b1;
                  run_min     <= new_min;
                  run_pos     <= new_pos;
                  if (last_win) begin
                     best_score <= new_min;
                     best_pos   <= new_pos;
                     best_valid <= 1'b1;
                     win_idx    <= '0;
                     first_win  <= 1'b1;
                  end else begin
                     win_idx    <= win_idx + POS_W'(1);
                     first_win  <= 1'b0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sad_score.sv
// tb_sad_score: table-driven and scoreboard bench for sad_score.
// Two instances share one input stream: default parameters and POS_W=2 for index wrap.

module tb_sad_score;

   localparam int DATA_W  = 4000;
   localparam int CHUNK_W = 200;
   localparam int CNT_W   = 12;
   localparam int NCHUNK  = DATA_W / CHUNK_W;
   localparam int NV      = 13;

   typedef struct {
      int ones;
      bit last;
      int e_score;
      bit e_bvalid;
      int e_bscore;
      int e_bpos;
      int e_bpos2;
   } vec_t;

   typedef struct {
      int score;
      bit bvalid;
      int bscore;
      int bpos;
      int bpos2;
      int tcyc;
   } exp_t;

   logic              clk;
   logic              rst_n;
   logic [DATA_W-1:0] d_in;
   logic              d_valid;
   logic              d_last;

   logic              d_ready_a, score_valid_a, best_valid_a;
   logic [CNT_W-1:0]  score_a, best_score_a;
   logic [15:0]       best_pos_a;
   logic              d_ready_b, score_valid_b, best_valid_b;
   logic [CNT_W-1:0]  score_b, best_score_b;
   logic [1:0]        best_pos_b;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t sb[$];
   vec_t vecs[NV];

   int   m_idx = 0;
   bit   m_first = 1'b1;
   int   m_min = 0;
   int   m_pos = 0;

   sad_score #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W), .CNT_W(CNT_W), .POS_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .d_in(d_in), .d_valid(d_valid), .d_last(d_last),
      .d_ready(d_ready_a), .score(score_a), .score_valid(score_valid_a),
      .best_score(best_score_a), .best_pos(best_pos_a), .best_valid(best_valid_a)
   );

   sad_score #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W), .CNT_W(CNT_W), .POS_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .d_in(d_in), .d_valid(d_valid), .d_last(d_last),
      .d_ready(d_ready_b), .score(score_b), .score_valid(score_valid_b),
      .best_score(best_score_b), .best_pos(best_pos_b), .best_valid(best_valid_b)
   );

   // Free-running clock and an edge counter (edge k sets cyc to k).
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout actual=stalled required=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Vector with exactly 'ones' set bits at random positions.
   task automatic makeVec(input int ones, output logic [DATA_W-1:0] d);
      int cnt;
      int p;
      d = '0;
      if (ones >= DATA_W) begin
         d = '1;
      end else begin
         cnt = 0;
         while (cnt < ones) begin
            p = $urandom_range(0, DATA_W - 1);
            if (!d[p]) begin
               d[p] = 1'b1;
               cnt++;
            end
         end
      end
   endtask

   // Reference frame model: earliest strict minimum, index reset per frame.
   task automatic modelWindow(input int sc, input bit last, input int tcyc, output exp_t e);
      if (m_first || sc < m_min) begin
         m_min = sc;
         m_pos = m_idx;
      end
      e.score  = sc;
      e.bvalid = last;
      e.bscore = m_min;
      e.bpos   = m_pos;
      e.bpos2  = m_pos % 4;
      e.tcyc   = tcyc;
      if (last) begin
         m_idx   = 0;
         m_first = 1'b1;
      end else begin
         m_idx++;
         m_first = 1'b0;
      end
   endtask

   // Present a window and wait (bounded) for its transfer edge; returns that edge number.
   task automatic applyStimulus(input logic [DATA_W-1:0] d, input bit last, input bit hold,
                                output int tcyc);
      int n;
      @(negedge clk);
      d_in    = d;
      d_valid = 1'b1;
      d_last  = last;
      n = 0;
      while (!d_ready_a && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!d_ready_a) begin
         failures++;
         $display("[TB] FAIL handshake_timeout actual=not_ready required=ready");
         tcyc = -1;
      end else begin
         @(posedge clk);
         #1;
         tcyc = cyc;
      end
      if (!hold) d_valid = 1'b0;
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checkOutput("scoreboard_drain", sb.size(), 0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_d_ready"}, d_ready_a, 1);
      checkOutput({tag, "_d_ready_w2"}, d_ready_b, 1);
      checkOutput({tag, "_score"}, score_a, 0);
      checkOutput({tag, "_score_valid"}, score_valid_a, 0);
      checkOutput({tag, "_best_score"}, best_score_a, 0);
      checkOutput({tag, "_best_pos"}, best_pos_a, 0);
      checkOutput({tag, "_best_valid"}, best_valid_a, 0);
      checkOutput({tag, "_best_pos_w2"}, best_pos_b, 0);
   endtask

   // Monitor: every result pulse pops one expectation and compares both instances.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (score_valid_a || score_valid_b || best_valid_a || best_valid_b)) begin
         if (sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_pulse actual=pulse required=none");
         end else begin
            e = sb.pop_front();
            checkOutput("score_valid", score_valid_a, 1);
            checkOutput("score_valid_w2", score_valid_b, 1);
            checkOutput("score", score_a, e.score);
            checkOutput("score_w2", score_b, e.score);
            checkOutput("best_valid", best_valid_a, e.bvalid);
            checkOutput("best_valid_w2", best_valid_b, e.bvalid);
            checkOutput("latency", cyc - e.tcyc, NCHUNK);
            if (e.bvalid) begin
               checkOutput("best_score", best_score_a, e.bscore);
               checkOutput("best_score_w2", best_score_b, e.bscore);
               checkOutput("best_pos", best_pos_a, e.bpos);
               checkOutput("best_pos_w2", best_pos_b, e.bpos2);
            end
         end
      end
   end

   initial begin
      logic [DATA_W-1:0] d;
      exp_t e;
      exp_t junk;
      int   t;
      int   prev;
      int   sc;

      rst_n   = 1'b0;
      d_in    = '0;
      d_valid = 1'b0;
      d_last  = 1'b0;

      // Extremes, tie/minimum frame, single-window frame, then the wrap frame.
      vecs[0]  = '{0,    1'b0, 0,    1'b0, 0,    0, 0};
      vecs[1]  = '{4000, 1'b1, 4000, 1'b1, 0,    0, 0};
      vecs[2]  = '{10,   1'b0, 10,   1'b0, 0,    0, 0};
      vecs[3]  = '{7,    1'b0, 7,    1'b0, 0,    0, 0};
      vecs[4]  = '{7,    1'b0, 7,    1'b0, 0,    0, 0};
      vecs[5]  = '{3,    1'b0, 3,    1'b0, 0,    0, 0};
      vecs[6]  = '{3,    1'b1, 3,    1'b1, 3,    3, 3};
      vecs[7]  = '{5,    1'b1, 5,    1'b1, 5,    0, 0};
      vecs[8]  = '{9,    1'b0, 9,    1'b0, 0,    0, 0};
      vecs[9]  = '{9,    1'b0, 9,    1'b0, 0,    0, 0};
      vecs[10] = '{9,    1'b0, 9,    1'b0, 0,    0, 0};
      vecs[11] = '{9,    1'b0, 9,    1'b0, 0,    0, 0};
      vecs[12] = '{1,    1'b1, 1,    1'b1, 1,    4, 0};

      repeat (3) @(negedge clk);
      #1;
      checkResetOutputs("reset_init");
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] table vectors");
      for (int i = 0; i < NV; i++) begin
         makeVec(vecs[i].ones, d);
         applyStimulus(d, vecs[i].last, 1'b0, t);
         modelWindow(vecs[i].ones, vecs[i].last, t, junk);
         e.score  = vecs[i].e_score;
         e.bvalid = vecs[i].e_bvalid;
         e.bscore = vecs[i].e_bscore;
         e.bpos   = vecs[i].e_bpos;
         e.bpos2  = vecs[i].e_bpos2;
         e.tcyc   = t;
         if (t >= 0) sb.push_back(e);
      end
      waitDrain();

      $display("[TB] chunk ordering and ready window");
      d = '0;
      d[0]    = 1'b1;
      d[199]  = 1'b1;
      d[200]  = 1'b1;
      d[3999] = 1'b1;
      applyStimulus(d, 1'b1, 1'b0, t);
      modelWindow(4, 1'b1, t, e);
      e.score  = 4;
      e.bscore = 4;
      e.bpos   = 0;
      e.bpos2  = 0;
      if (t >= 0) sb.push_back(e);
      for (int k = 0; k <= NCHUNK; k++) begin
         @(negedge clk);
         checkOutput("ready_low_after_transfer", d_ready_a, 0);
      end
      @(negedge clk);
      checkOutput("ready_back_high", d_ready_a, 1);
      waitDrain();

      $display("[TB] backpressure with d_valid held high");
      prev = -1;
      for (int k = 0; k < 4; k++) begin
         makeVec($urandom_range(0, 300), d);
         sc = $countones(d);
         applyStimulus(d, (k == 3), 1'b1, t);
         modelWindow(sc, (k == 3), t, e);
         if (t >= 0) sb.push_back(e);
         if (k > 0) checkOutput("transfer_gap", t - prev, NCHUNK + 2);
         prev = t;
      end
      @(negedge clk);
      d_valid = 1'b0;
      waitDrain();

      $display("[TB] reset mid-window");
      makeVec(20, d);
      applyStimulus(d, 1'b0, 1'b0, t);
      modelWindow(20, 1'b0, t, e);
      if (t >= 0) sb.push_back(e);
      waitDrain();
      makeVec(30, d);
      applyStimulus(d, 1'b1, 1'b0, t);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkResetOutputs("reset_mid");
      sb.delete();
      m_idx   = 0;
      m_first = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkResetOutputs("reset_release");
      repeat (25) @(negedge clk);
      makeVec(50, d);
      applyStimulus(d, 1'b1, 1'b0, t);
      modelWindow(50, 1'b1, t, e);
      e.bpos  = 0;
      e.bpos2 = 0;
      if (t >= 0) sb.push_back(e);
      waitDrain();

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
